// File: rtl/pcie_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pcie_uart_tx_arbiter
// Purpose  : Whole-message round-robin arbiter sharing one UART TX byte path
//            between two PCIe-side sources, with optional ID prefix and stall abort.
// Revision : 1.0  initial release
// ============================================================================
module pcie_uart_tx_arbiter #(
  parameter int unsigned PREFIX_EN = 1,
  parameter logic [7:0]  PREFIX0   = 8'h31,
  parameter logic [7:0]  PREFIX1   = 8'h32,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic       clk_125_clk,
  input  logic       rst_125_reset,
  input  logic       s0_valid,
  input  logic [7:0] s0_data,
  input  logic       s0_last,
  output logic       s0_ready,
  input  logic       s1_valid,
  input  logic [7:0] s1_data,
  input  logic       s1_last,
  output logic       s1_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  output logic [1:0] grant,
  output logic       busy,
  output logic [1:0] timeout
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] c_stall_limit = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PREFIX = 2'd1,
    ST_DATA   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [1:0]       r_grant;
  logic [1:0]       w_grant_nx;
  logic             r_last;
  logic             w_last_nx;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nx;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_tx_valid;
  logic [7:0]       r_tx_data;
  logic [1:0]       r_timeout;
  logic [1:0]       w_timeout_nx;
  logic             w_load;
  logic [7:0]       w_load_data;
  logic             w_slot_free;
  logic             w_owner;
  logic             w_src_valid;
  logic [7:0]       w_src_data;
  logic             w_src_last;
  logic             w_in_data;
  logic             w_accept;

  assign w_slot_free = !r_tx_valid || tx_ready;
  assign w_owner     = r_grant[1];
  assign w_src_valid = w_owner ? s1_valid : s0_valid;
  assign w_src_data  = w_owner ? s1_data  : s0_data;
  assign w_src_last  = w_owner ? s1_last  : s0_last;
  assign w_in_data   = (r_state == ST_DATA);
  assign w_accept    = w_in_data && w_src_valid && w_slot_free;
  assign w_cnt_inc   = r_cnt + 1'b1;

  assign s0_ready = w_in_data && r_grant[0] && w_slot_free;
  assign s1_ready = w_in_data && r_grant[1] && w_slot_free;
  assign tx_valid = r_tx_valid;
  assign tx_data  = r_tx_data;
  assign grant    = r_grant;
  assign busy     = (r_state != ST_IDLE);
  assign timeout  = r_timeout;

  always_comb begin
    w_state_nx   = r_state;
    w_grant_nx   = r_grant;
    w_last_nx    = r_last;
    w_cnt_nx     = r_cnt;
    w_timeout_nx = 2'b00;
    w_load       = 1'b0;
    w_load_data  = 8'h00;
    case (r_state)
      ST_IDLE: begin
        if (s0_valid || s1_valid) begin
          // On a tie the source that did not own the previous message wins.
          if (s0_valid && s1_valid) begin
            w_grant_nx = r_last ? 2'b01 : 2'b10;
          end else begin
            w_grant_nx = s0_valid ? 2'b01 : 2'b10;
          end
          w_state_nx = (PREFIX_EN != 0) ? ST_PREFIX : ST_DATA;
          w_cnt_nx   = '0;
        end
      end
      ST_PREFIX: begin
        if (w_slot_free) begin
          w_load      = 1'b1;
          w_load_data = w_owner ? PREFIX1 : PREFIX0;
          w_state_nx  = ST_DATA;
          w_cnt_nx    = '0;
        end
      end
      ST_DATA: begin
        if (w_accept) begin
          w_load      = 1'b1;
          w_load_data = w_src_data;
          w_cnt_nx    = '0;
          if (w_src_last) begin
            w_state_nx = ST_IDLE;
            w_grant_nx = 2'b00;
            w_last_nx  = w_owner;
          end
        end else if ((TIMEOUT != 0) && !w_src_valid) begin
          // Only source starvation counts; a stalled UART never aborts a message.
          w_cnt_nx = w_cnt_inc;
          if (w_cnt_inc == c_stall_limit) begin
            w_timeout_nx = r_grant;
            w_state_nx   = ST_IDLE;
            w_grant_nx   = 2'b00;
            w_last_nx    = w_owner;
            w_cnt_nx     = '0;
          end
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_grant_nx = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk_125_clk) begin
    if (rst_125_reset) begin
      r_state    <= ST_IDLE;
      r_grant    <= 2'b00;
      r_last     <= 1'b1;
      r_cnt      <= '0;
      r_timeout  <= 2'b00;
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_state   <= w_state_nx;
      r_grant   <= w_grant_nx;
      r_last    <= w_last_nx;
      r_cnt     <= w_cnt_nx;
      r_timeout <= w_timeout_nx;
      if (w_load) begin
        r_tx_valid <= 1'b1;
        r_tx_data  <= w_load_data;
      end else if (tx_ready) begin
        r_tx_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pcie_uart_tx_arbiter.sv
`default_nettype none
// Bench for pcie_uart_tx_arbiter: message-level scoreboard model plus
// directed latency, fairness, timeout and reset scenarios.
module tb_pcie_uart_tx_arbiter;

  localparam logic [7:0] c_p0 = 8'h31;
  localparam logic [7:0] c_p1 = 8'h32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s0_valid = 1'b0, s1_valid = 1'b0;
  logic [7:0] s0_data = 8'h00, s1_data = 8'h00;
  logic       s0_last = 1'b0, s1_last = 1'b0;
  logic       s0_ready, s1_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready = 1'b1;
  logic [1:0] grant;
  logic       busy;
  logic [1:0] timeout;

  pcie_uart_tx_arbiter #(
    .PREFIX_EN(1), .PREFIX0(c_p0), .PREFIX1(c_p1), .TIMEOUT(8)
  ) dut (
    .clk_125_clk(clk), .rst_125_reset(rst),
    .s0_valid(s0_valid), .s0_data(s0_data), .s0_last(s0_last), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_data(s1_data), .s1_last(s1_last), .s1_ready(s1_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .grant(grant), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Source message storage: bytes, last flags, length, current offer index.
  logic [7:0] sb [2][0:255];
  logic       sl [2][0:255];
  int         slen [2];
  int         sidx [2];
  int         gap  [2];

  // Scoreboard state.
  bit         model_en = 1'b0;
  logic [1:0] m_grant;
  logic       m_ptr;
  logic [7:0] expq [$];
  logic [7:0] txlog [$];
  int         own_log [$];
  logic [1:0] prev_grant;
  bit         prev_hold;
  logic [7:0] prev_data;

  always @(negedge clk) begin
    if (rst) begin
      m_grant    = 2'b00;
      m_ptr      = 1'b1;
      expq.delete();
      prev_hold  = 1'b0;
      prev_grant = 2'b00;
    end else begin
      if (tx_valid && tx_ready) txlog.push_back(tx_data);
      if (prev_hold) chk("tx_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, prev_data});
      prev_hold = tx_valid && !tx_ready;
      prev_data = tx_data;
      if (grant != 2'b00 && prev_grant == 2'b00) own_log.push_back(int'(grant[1]));
      prev_grant = grant;
      if (model_en) begin
        bit acc0, acc1;
        chk("grant", 32'(grant), 32'(m_grant));
        chk("busy", 32'(busy), 32'(m_grant != 2'b00));
        chk("timeout_quiet", 32'(timeout), 32'd0);
        chk("ready_nonowner", 32'({s1_ready & ~m_grant[1], s0_ready & ~m_grant[0]}), 32'd0);
        if ((s0_ready || s1_ready) && tx_valid && !tx_ready)
          chk("ready_slot_full", 32'd1, 32'd0);
        if (tx_valid && tx_ready) begin
          if (expq.size() == 0) chk("tx_unexpected", 32'(tx_data), 32'h100);
          else chk("tx_byte", 32'(tx_data), 32'(expq.pop_front()));
        end
        acc0 = s0_valid && s0_ready;
        acc1 = s1_valid && s1_ready;
        if (m_grant == 2'b00) begin
          if (s0_valid || s1_valid) begin
            int n;
            n = (s0_valid && s1_valid) ? int'(!m_ptr) : (s0_valid ? 0 : 1);
            m_grant = (n == 0) ? 2'b01 : 2'b10;
            expq.push_back(n == 0 ? c_p0 : c_p1);
            for (int j = sidx[n]; j < 256; j++) begin
              expq.push_back(sb[n][j]);
              if (sl[n][j]) break;
            end
          end
        end else begin
          int n;
          n = m_grant[1] ? 1 : 0;
          if (((n == 0) ? acc0 : acc1) && sl[n][sidx[n]]) begin
            m_grant = 2'b00;
            m_ptr   = n[0];
          end
        end
      end
    end
  end

  task automatic do_reset(input bit en);
    @(posedge clk); #1;
    rst = 1'b1; model_en = en;
    s0_valid = 1'b0; s1_valid = 1'b0; s0_last = 1'b0; s1_last = 1'b0;
    tx_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    txlog.delete();
    own_log.delete();
  endtask

  task automatic gen_msgs(input int n, input int count, input int maxlen);
    slen[n] = 0; sidx[n] = 0; gap[n] = 0;
    repeat (count) begin
      int len;
      len = $urandom_range(maxlen, 1);
      for (int k = 0; k < len; k++) begin
        sb[n][slen[n]] = 8'($urandom);
        sl[n][slen[n]] = (k == len - 1);
        slen[n]++;
      end
    end
  endtask

  task automatic apply_src();
    s0_valid = (sidx[0] < slen[0]) && (gap[0] == 0);
    s1_valid = (sidx[1] < slen[1]) && (gap[1] == 0);
    s0_data  = (sidx[0] < slen[0]) ? sb[0][sidx[0]] : 8'h00;
    s1_data  = (sidx[1] < slen[1]) ? sb[1][sidx[1]] : 8'h00;
    s0_last  = (sidx[0] < slen[0]) ? sl[0][sidx[0]] : 1'b0;
    s1_last  = (sidx[1] < slen[1]) ? sl[1][sidx[1]] : 1'b0;
  endtask

  // Caller is just after a rising edge; returns once everything has drained.
  task automatic run_sources(input int budget, input int mid_gap, input int idle_gap, input int rdy_pct);
    bit acc [2];
    bit done;
    done = 1'b0;
    apply_src();
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      acc[0] = s0_valid && s0_ready;
      acc[1] = s1_valid && s1_ready;
      done = (sidx[0] >= slen[0]) && (sidx[1] >= slen[1]) && (grant == 2'b00) && !tx_valid;
      @(posedge clk); #1;
      for (int n = 0; n < 2; n++) begin
        if (acc[n]) begin
          gap[n] = sl[n][sidx[n]] ? $urandom_range(idle_gap, 0) : $urandom_range(mid_gap, 0);
          sidx[n]++;
        end else if (gap[n] > 0) begin
          gap[n]--;
        end
      end
      tx_ready = ($urandom_range(99, 0) < rdy_pct);
      apply_src();
    end
    chk("run_done", 32'(done), 32'd1);
    tx_ready = 1'b1;
    chk("src0_consumed", 32'(sidx[0]), 32'(slen[0]));
    chk("src1_consumed", 32'(sidx[1]), 32'(slen[1]));
    chk("expq_empty", 32'(expq.size()), 32'd0);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] exp_sim [6];
    int c0;

    // Directed latency: single message "AB" from source 0.
    do_reset(1'b0);
    s0_valid = 1'b1; s0_data = 8'h41; s0_last = 1'b0;
    @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_txvalid", 32'(tx_valid), 32'd0);
    chk("rst_txdata", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    cyc(); @(negedge clk);
    chk("c1_grant", 32'(grant), 32'd1);
    chk("c1_busy", 32'(busy), 32'd1);
    chk("c1_txvalid", 32'(tx_valid), 32'd0);
    chk("c1_s0ready", 32'(s0_ready), 32'd0);
    cyc(); @(negedge clk);
    chk("c2_txvalid", 32'(tx_valid), 32'd1);
    chk("c2_prefix", 32'(tx_data), 32'h31);
    chk("c2_s0ready", 32'(s0_ready), 32'd1);
    cyc(); s0_data = 8'h42; s0_last = 1'b1; @(negedge clk);
    chk("c3_data", 32'(tx_data), 32'h41);
    chk("c3_grant", 32'(grant), 32'd1);
    cyc(); s0_valid = 1'b0; s0_last = 1'b0; @(negedge clk);
    chk("c4_data", 32'(tx_data), 32'h42);
    chk("c4_grant", 32'(grant), 32'd0);
    chk("c4_busy", 32'(busy), 32'd0);
    cyc(); @(negedge clk);
    chk("c5_txvalid", 32'(tx_valid), 32'd0);

    // Simultaneous start: source 0 must win the first tie, no interleave.
    do_reset(1'b1);
    slen[0] = 2; sidx[0] = 0; gap[0] = 0; slen[1] = 2; sidx[1] = 0; gap[1] = 0;
    sb[0][0] = 8'h41; sl[0][0] = 1'b0; sb[0][1] = 8'h42; sl[0][1] = 1'b1;
    sb[1][0] = 8'h43; sl[1][0] = 1'b0; sb[1][1] = 8'h44; sl[1][1] = 1'b1;
    run_sources(100, 0, 0, 100);
    exp_sim = '{8'h31, 8'h41, 8'h42, 8'h32, 8'h43, 8'h44};
    chk("sim_len", 32'(txlog.size()), 32'd6);
    for (int i = 0; i < 6 && i < txlog.size(); i++) chk("sim_byte", 32'(txlog[i]), 32'(exp_sim[i]));

    // Fairness: both sources keep offering one-byte messages.
    own_log.delete();
    gen_msgs(0, 10, 1); gen_msgs(1, 10, 1);
    run_sources(400, 0, 0, 100);
    c0 = 0;
    foreach (own_log[i]) if (own_log[i] == 0) c0++;
    chk("fair_msgs", 32'(own_log.size()), 32'd20);
    chk("fair_src0", 32'(c0), 32'd10);
    for (int i = 0; i < own_log.size(); i++) chk("fair_alt", 32'(own_log[i]), 32'(i % 2));

    // Randomised traffic with source gaps and UART backpressure.
    gen_msgs(0, 30, 6); gen_msgs(1, 30, 6);
    run_sources(6000, 4, 6, 70);

    // Stall timeout on source 1 with source 0 waiting.
    do_reset(1'b0);
    s1_valid = 1'b1; s1_data = 8'h55; s1_last = 1'b0;
    @(negedge clk); chk("to_c0_grant", 32'(grant), 32'd0);
    cyc(); @(negedge clk); chk("to_c1_grant", 32'(grant), 32'd2);
    cyc(); @(negedge clk); chk("to_c2_s1ready", 32'(s1_ready), 32'd1);
    cyc(); s1_valid = 1'b0; s0_valid = 1'b1; s0_data = 8'h66; s0_last = 1'b1;
    for (int k = 3; k <= 10; k++) begin
      @(negedge clk);
      chk("to_stall_grant", 32'(grant), 32'd2);
      chk("to_stall_quiet", 32'(timeout), 32'd0);
      chk("to_stall_s0ready", 32'(s0_ready), 32'd0);
      cyc();
    end
    @(negedge clk);
    chk("to_pulse", 32'(timeout), 32'd2);
    chk("to_pulse_grant", 32'(grant), 32'd0);
    cyc(); @(negedge clk);
    chk("to_regrant", 32'(grant), 32'd1);
    chk("to_pulse_once", 32'(timeout), 32'd0);
    cyc(); @(negedge clk);
    chk("to_s0ready", 32'(s0_ready), 32'd1);
    cyc(); s0_valid = 1'b0; s0_last = 1'b0;
    repeat (3) cyc();
    exp_sim = '{8'h32, 8'h55, 8'h31, 8'h66, 8'h00, 8'h00};
    chk("to_len", 32'(txlog.size()), 32'd4);
    for (int i = 0; i < 4 && i < txlog.size(); i++) chk("to_byte", 32'(txlog[i]), 32'(exp_sim[i]));

    // Reset in the middle of a source 0 message.
    do_reset(1'b0);
    s0_valid = 1'b1; s0_data = 8'h10; s0_last = 1'b0;
    repeat (3) cyc();
    @(negedge clk); chk("mr_pre_busy", 32'(busy), 32'd1);
    cyc(); rst = 1'b1; tx_ready = 1'b0; s0_valid = 1'b0;
    cyc(); rst = 1'b0;
    @(negedge clk);
    chk("mr_txvalid", 32'(tx_valid), 32'd0);
    chk("mr_txdata", 32'(tx_data), 32'd0);
    chk("mr_grant", 32'(grant), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_s0ready", 32'(s0_ready), 32'd0);
    cyc(); tx_ready = 1'b1; txlog.delete();
    s1_valid = 1'b1; s1_data = 8'h77; s1_last = 1'b1;
    begin
      bit got;
      got = 1'b0;
      for (int k = 0; k < 50 && !got; k++) begin
        @(negedge clk);
        if (s1_ready) got = 1'b1;
        else cyc();
      end
      chk("mr_s1_accepted", 32'(got), 32'd1);
      cyc(); s1_valid = 1'b0; s1_last = 1'b0;
    end
    repeat (3) cyc();
    chk("mr_len", 32'(txlog.size()), 32'd2);
    if (txlog.size() >= 2) begin
      chk("mr_prefix", 32'(txlog[0]), 32'h32);
      chk("mr_byte", 32'(txlog[1]), 32'h77);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/pcie_uart_tx_arbiter.md
# pcie_uart_tx_arbiter

Shares the single UART transmit path between two message sources, one driven from each PCIe endpoint's host-visible register space. Each source presents a byte stream framed into messages by a `last` flag. The block grants the UART to one source per whole message, using round-robin between sources. It optionally prepends a source-ID byte to each message and aborts stalled messages with a timeout. It sits between the two PCIe-side byte buffers and the UART transmitter core that drives `uart_conduit_txd`.

## Interface
Parameters:
- PREFIX_EN, 1: when 1, emit one source-ID byte before each granted message.
- PREFIX0, 8'h31: ID byte for source 0 (PCIe1, ASCII '1').
- PREFIX1, 8'h32: ID byte for source 1 (PCIe2, ASCII '2').
- TIMEOUT, 1024: number of source-stall cycles tolerated mid-message; 0 disables the timeout.

Ports (one clock; reset is synchronous and active-high):
- clk_125_clk  in  1  system clock, 125 MHz.
- rst_125_reset  in  1  synchronous, active-high reset.
- s0_valid / s1_valid  in  1  source byte valid.
- s0_data / s1_data  in  8  source byte.
- s0_last / s1_last  in  1  byte is the final byte of its message.
- s0_ready / s1_ready  out  1  byte accepted when valid && ready.
- tx_valid  out  1  registered byte available to the UART core.
- tx_data  out  8  registered byte.
- tx_ready  in  1  UART core accepts the byte when tx_valid && tx_ready.
- grant  out  2  one-hot current owner; 00 when idle.
- busy  out  1  state != IDLE.
- timeout  out  2  one-cycle pulse per source on message abort.

## Operation
- FSM states: IDLE, PREFIX, DATA.
- Output register: tx_valid/tx_data form a one-entry buffer.
  - "Slot free" = !tx_valid || tx_ready.
  - Loading requires slot free.
  - tx_data holds stable while tx_valid && !tx_ready.
- IDLE:
  - If any s*_valid is high, choose the owner and register grant.
  - Next state is PREFIX if PREFIX_EN, else DATA.
  - Choice rule: if both sources are valid, pick the one not granted last; otherwise pick the sole requester.
  - Last-grant pointer resets to 1, so source 0 wins the first tie.
- PREFIX: when slot free, load PREFIXn into the output register, then go to DATA.
- DATA:
  - sN_ready = grant[N] && slot free; the other source's ready is 0.
  - An accepted byte loads the output register.
  - If the accepted byte has last=1: go to IDLE, clear grant, and set the last-grant pointer to N.
- Timeout (TIMEOUT > 0):
  - The stall counter clears on entry to DATA and on every accepted byte.
  - It increments each DATA cycle in which the granted sN_valid is 0.
  - tx_ready backpressure does not count.
  - When the counter reaches TIMEOUT: pulse timeout[N], go to IDLE, clear grant, set the pointer to N.
  - The partial message stays as sent; no terminator is inserted.
- Non-granted sources see ready=0 and must hold their data.
- The output register drains independently of the FSM. IDLE arbitration may overlap the drain of the final byte.
- No interleaving: bytes from one granted message are never mixed with bytes from the other source.

## Timing
- Reset values: tx_valid=0, tx_data=0, s0_ready=s1_ready=0, grant=00, busy=0, timeout=00, state=IDLE, stall counter=0.
- Reset mid-message:
  - Next cycle, all outputs are at their reset values, including tx_valid=0 regardless of tx_ready.
  - The in-flight byte and the message remainder are dropped.
- Latency from idle, PREFIX_EN=1, tx_ready=1:
  - s0_valid rises in cycle 0.
  - grant=01 and PREFIX in cycle 1.
  - tx_valid with PREFIX0 in cycle 2; s0_ready=1 in cycle 2.
  - The first data byte appears on tx_data in cycle 3.
- With PREFIX_EN=0, the first data byte appears on tx_data in cycle 2.
- Throughput: one byte per cycle while tx_ready=1 and the source is valid.
- Message-to-message gap: one IDLE cycle, plus one PREFIX cycle when PREFIX_EN=1.
- timeout pulse: asserted in the same cycle grant returns to 00.

## Test plan
- Single message: s0 sends 0x41, 0x42 (last on 0x42), tx_ready=1, PREFIX_EN=1 -> tx stream 0x31, 0x41, 0x42. grant=01 for 3 cycles, then 00.
- Simultaneous start after reset: s0 sends "AB", s1 sends "CD" -> tx stream 0x31, 0x41, 0x42, 0x32, 0x43, 0x44, with no interleave.
- Fairness: both sources continuously offer 1-byte messages -> grant alternates 01, 10, 01, 10; each source gets exactly 50% of messages over 20 messages.
- Backpressure: tx_ready=0 for 5 cycles mid-message -> tx_data held constant, no byte lost or duplicated, timeout=00.
- Timeout (TIMEOUT=8): s1 granted, sends 0x55 without last, then s1_valid=0 -> timeout[1] pulses 8 cycles after acceptance, and pending s0 is granted in the next cycle.
- Reset mid-message: assert rst_125_reset during s0 DATA -> next cycle tx_valid=0 and grant=00. After release, a new s1 message is sent cleanly with prefix 0x32.
